// File: rtl/avmm_burst_mem_slave.sv
// Avalon-MM burst memory responder: on-chip RAM answering burst reads and
// byte-enabled burst writes, with optional LFSR-driven wait-state injection.
module avmm_burst_mem_slave #(
  parameter int unsigned DW        = 128,
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE      = 32'h0000_0000,
  parameter bit          STALL_EN  = 1'b0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     avs_address,
  input  logic            avs_read,
  input  logic            avs_write,
  input  logic [DW-1:0]   avs_writedata,
  input  logic [DW/8-1:0] avs_byteenable,
  input  logic [7:0]      avs_burstcount,
  output logic [DW-1:0]   avs_readdata,
  output logic            avs_readdatavalid,
  output logic            avs_waitrequest,
  output logic            err_sticky
);
  localparam int unsigned BW   = DW / 8;
  localparam int unsigned OFFW = $clog2(BW);
  localparam int unsigned AW   = $clog2(MEM_WORDS);
  // Signed word index: the top bit marks an address below BASE.
  localparam int unsigned IW   = 33;

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;

  state_t          state, state_nx;
  logic [15:0]     lfsr;
  logic            stall;
  logic [IW-1:0]   idx, idx_nx, cmd_idx, beat_idx;
  logic [7:0]      remaining, remaining_nx, cmd_count;
  logic            wr_fire, rd_fire, err_set, beat_ok;
  logic [DW-1:0]   mem [MEM_WORDS];

  function automatic logic in_range(input logic [IW-1:0] i);
    return !i[IW-1] && (i[IW-2:0] < 32'(MEM_WORDS));
  endfunction

  assign stall           = STALL_EN && (lfsr[1:0] == 2'b00);
  assign avs_waitrequest = rst | (state == RD_BURST) | stall;
  assign cmd_count       = (avs_burstcount == 8'd0) ? 8'd1 : avs_burstcount;
  assign cmd_idx         = IW'($signed({1'b0, avs_address} - {1'b0, BASE}) >>> OFFW);
  assign beat_idx        = (state == IDLE) ? cmd_idx : idx;
  assign beat_ok         = in_range(beat_idx);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and per-cycle beat decisions
  always_comb begin
    state_nx     = state;
    idx_nx       = idx;
    remaining_nx = remaining;
    wr_fire      = 1'b0;
    rd_fire      = 1'b0;
    err_set      = 1'b0;
    case (state)
      IDLE: begin
        if (avs_write && !avs_waitrequest) begin
          wr_fire = beat_ok;
          err_set = !beat_ok || avs_read;
          if (cmd_count > 8'd1) begin
            state_nx     = WR_BURST;
            idx_nx       = cmd_idx + IW'(1);
            remaining_nx = cmd_count - 8'd1;
          end
        end else if (avs_read && !avs_waitrequest) begin
          state_nx     = RD_BURST;
          idx_nx       = cmd_idx;
          remaining_nx = cmd_count;
        end
      end
      RD_BURST: begin
        if (!stall) begin
          rd_fire      = 1'b1;
          err_set      = !beat_ok;
          idx_nx       = idx + IW'(1);
          remaining_nx = remaining - 8'd1;
          if (remaining == 8'd1) state_nx = IDLE;
        end
      end
      WR_BURST: begin
        err_set = avs_read;
        if (avs_write && !avs_waitrequest) begin
          wr_fire      = beat_ok;
          if (!beat_ok) err_set = 1'b1;
          idx_nx       = idx + IW'(1);
          remaining_nx = remaining - 8'd1;
          if (remaining == 8'd1) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Burst counters, LFSR, registered read data and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr              <= LFSR_SEED;
      idx               <= '0;
      remaining         <= '0;
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
      err_sticky        <= 1'b0;
    end else begin
      lfsr              <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      idx               <= idx_nx;
      remaining         <= remaining_nx;
      avs_readdatavalid <= rd_fire;
      if (rd_fire) avs_readdata <= beat_ok ? mem[beat_idx[AW-1:0]] : '0;
      if (err_set) err_sticky <= 1'b1;
    end
  end

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < int'(BW); b++) begin
        if (avs_byteenable[b]) mem[beat_idx[AW-1:0]][b*8 +: 8] <= avs_writedata[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_avmm_burst_mem_slave.sv
// Bench for avmm_burst_mem_slave: a no-stall and a stall-injecting instance,
// directed timing/corner sequences, a vector table, and random bursts vs. a memory model.
module tb_avmm_burst_mem_slave;
  localparam int unsigned DW     = 128;
  localparam int unsigned WORDS  = 1024;
  localparam longint      BASE_L = 0;

  typedef struct {
    logic [31:0]  addr;
    logic [15:0]  be;
    logic [127:0] wd;
    logic [127:0] exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  address    [2];
  logic         read       [2];
  logic         write      [2];
  logic [127:0] writedata  [2];
  logic [15:0]  byteenable [2];
  logic [7:0]   burstcount [2];
  logic [127:0] readdata   [2];
  logic         rdvalid    [2];
  logic         waitreq    [2];
  logic         err        [2];

  logic [127:0] rq0[$];
  logic [127:0] rq1[$];
  logic [127:0] mdl  [2][WORDS];
  logic         merr [2];

  int n_tests = 0;
  int n_fail  = 0;

  avmm_burst_mem_slave #(
    .DW(DW), .MEM_WORDS(WORDS), .BASE(32'h0), .STALL_EN(1'b0), .LFSR_SEED(16'hACE1)
  ) u_fast (
    .clk(clk), .rst(rst), .avs_address(address[0]), .avs_read(read[0]), .avs_write(write[0]),
    .avs_writedata(writedata[0]), .avs_byteenable(byteenable[0]), .avs_burstcount(burstcount[0]),
    .avs_readdata(readdata[0]), .avs_readdatavalid(rdvalid[0]), .avs_waitrequest(waitreq[0]),
    .err_sticky(err[0])
  );

  avmm_burst_mem_slave #(
    .DW(DW), .MEM_WORDS(WORDS), .BASE(32'h0), .STALL_EN(1'b1), .LFSR_SEED(16'hACE1)
  ) u_stall (
    .clk(clk), .rst(rst), .avs_address(address[1]), .avs_read(read[1]), .avs_write(write[1]),
    .avs_writedata(writedata[1]), .avs_byteenable(byteenable[1]), .avs_burstcount(burstcount[1]),
    .avs_readdata(readdata[1]), .avs_readdatavalid(rdvalid[1]), .avs_waitrequest(waitreq[1]),
    .err_sticky(err[1])
  );

  always #5 clk = ~clk;

  // Collect every returned read beat
  always @(negedge clk) begin
    if (rdvalid[0]) rq0.push_back(readdata[0]);
    if (rdvalid[1]) rq1.push_back(readdata[1]);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", nm, act, exp);
    end
  endtask

  function automatic int qsize(input int u);
    return (u == 0) ? rq0.size() : rq1.size();
  endfunction

  function automatic logic [127:0] qpop(input int u);
    if (u == 0) return rq0.pop_front();
    return rq1.pop_front();
  endfunction

  // Word index of beat i, or -1 when that beat falls outside the RAM
  function automatic longint beat_word(input logic [31:0] addr, input int i);
    longint off;
    off = longint'(addr) - BASE_L;
    if (off < 0) return -1;
    if (off / 16 + i >= longint'(WORDS)) return -1;
    return off / 16 + i;
  endfunction

  task automatic wait_accept(input int u);
    int t;
    t = 0;
    while (waitreq[u] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout u%0d: waitrequest got 1 required 0", u);
    end
    @(posedge clk);
  endtask

  task automatic wr_burst(input int u, input logic [31:0] addr, input int n,
                          input logic [127:0] d[$], input logic [15:0] be[$]);
    longint w;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      write[u] = 1'b1; address[u] = addr; burstcount[u] = 8'(n);
      writedata[u] = d[i]; byteenable[u] = be[i];
      wait_accept(u);
      w = beat_word(addr, i);
      if (w < 0) merr[u] = 1'b1;
      else for (int b = 0; b < 16; b++)
        if (be[i][b]) mdl[u][int'(w)][b*8 +: 8] = d[i][b*8 +: 8];
    end
    @(negedge clk);
    write[u] = 1'b0;
  endtask

  task automatic wr1(input int u, input logic [31:0] addr, input logic [127:0] data,
                     input logic [15:0] be);
    logic [127:0] d[$];
    logic [15:0]  b[$];
    d.push_back(data);
    b.push_back(be);
    wr_burst(u, addr, 1, d, b);
  endtask

  task automatic rd_burst(input int u, input logic [31:0] addr, input logic [7:0] bc,
                          output logic [127:0] first);
    int n, t, got;
    longint w;
    logic [127:0] act, exp;
    n = (bc == 8'd0) ? 1 : int'(bc);
    t = 0;
    first = '0;
    if (u == 0) rq0.delete(); else rq1.delete();
    @(negedge clk);
    read[u] = 1'b1; address[u] = addr; burstcount[u] = bc;
    wait_accept(u);
    @(negedge clk);
    read[u] = 1'b0;
    while (qsize(u) < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    got = qsize(u);
    check($sformatf("rd_count u%0d @%h", u, addr), 128'(got), 128'(n));
    for (int i = 0; i < got && i < n; i++) begin
      act = qpop(u);
      w = beat_word(addr, i);
      if (w < 0) begin
        exp = '0;
        merr[u] = 1'b1;
      end else exp = mdl[u][int'(w)];
      if (i == 0) first = act;
      check($sformatf("rd_data u%0d @%h beat%0d", u, addr, i), act, exp);
    end
  endtask

  initial begin
    vec_t         tbl[5];
    logic [127:0] d[$];
    logic [15:0]  be[$];
    logic [127:0] f;
    int           waits, cnt, t;

    for (int u = 0; u < 2; u++) begin
      address[u] = '0; read[u] = 1'b0; write[u] = 1'b0; writedata[u] = '0;
      byteenable[u] = '0; burstcount[u] = '0; merr[u] = 1'b0;
    end

    // Reset values
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check1($sformatf("rst_wait u%0d", u), waitreq[u], 1'b1);
      check1($sformatf("rst_valid u%0d", u), rdvalid[u], 1'b0);
      check($sformatf("rst_rdata u%0d", u), readdata[u], '0);
      check1($sformatf("rst_err u%0d", u), err[u], 1'b0);
    end
    rst = 1'b0;
    #1 check1("wait_after_rst u0", waitreq[0], 1'b0);

    // Preload word k = {16{k[7:0]}} with 128-beat bursts
    for (int u = 0; u < 2; u++) begin
      for (int blk = 0; blk < 8; blk++) begin
        d.delete(); be.delete();
        for (int k = 0; k < 128; k++) begin
          d.push_back({16{8'(blk*128 + k)}});
          be.push_back(16'hFFFF);
        end
        wr_burst(u, 32'(blk*128*16), 128, d, be);
      end
    end

    // Read latency and waitrequest window: 4-beat read at 0x40
    @(negedge clk);
    read[0] = 1'b1; address[0] = 32'h40; burstcount[0] = 8'd4;
    check1("t_wait_before_accept", waitreq[0], 1'b0);
    @(posedge clk);
    waits = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      read[0] = 1'b0;
      if (waitreq[0]) waits++;
      check1($sformatf("t_valid c%0d", c), rdvalid[0], (c >= 1 && c <= 4));
      if (c >= 1 && c <= 4) check($sformatf("t_data c%0d", c), readdata[0], {16{8'(3 + c)}});
    end
    check("t_wait_cycles", 128'(waits), 128'(4));
    rq0.delete();

    // Byte-enable masking on word 0
    wr1(0, 32'h0, '1, 16'hFFFF);
    wr1(0, 32'h0, '0, 16'h00F0);
    rd_burst(0, 32'h0, 8'd1, f);
    check("be_mask", f, {64'hFFFF_FFFF_FFFF_FFFF, 32'h0, 32'hFFFF_FFFF});

    // 3-beat write burst at 0x100
    d.delete(); be.delete();
    for (int k = 1; k <= 3; k++) begin
      d.push_back(128'(k));
      be.push_back(16'hFFFF);
    end
    wr_burst(0, 32'h100, 3, d, be);
    rd_burst(0, 32'h100, 8'd1, f); check("wburst w16", f, 128'd1);
    rd_burst(0, 32'h110, 8'd1, f); check("wburst w17", f, 128'd2);
    rd_burst(0, 32'h120, 8'd1, f); check("wburst w18", f, 128'd3);
    check1("wburst_err", err[0], 1'b0);

    // Single-beat write/readback vectors
    tbl[0] = '{32'h20,  16'h0001, {16{8'hAB}}, {{15{8'h02}}, 8'hAB}};
    tbl[1] = '{32'h90,  16'h8000, {16{8'h5C}}, {8'h5C, {15{8'h09}}}};
    tbl[2] = '{32'h3A0, 16'hFFFF, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF,
                                  128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF};
    tbl[3] = '{32'h4B0, 16'h0000, {16{8'hFF}}, {16{8'h4B}}};
    tbl[4] = '{32'h5C,  16'h00FF, {16{8'h77}}, {{8{8'h05}}, {8{8'h77}}}};
    for (int i = 0; i < 5; i++) begin
      wr1(0, tbl[i].addr, tbl[i].wd, tbl[i].be);
      rd_burst(0, tbl[i].addr & 32'hFFFF_FFF0, 8'd1, f);
      check($sformatf("vec%0d", i), f, tbl[i].exp);
    end

    // Burstcount 0 behaves as a single beat
    rd_burst(0, 32'h300, 8'd0, f);
    check("bc0_data", f, {16{8'h30}});

    // Random traffic on both instances, the second with wait-state injection
    for (int u = 0; u < 2; u++) begin
      for (int it = 0; it < 40; it++) begin
        int wi, n;
        wi = int'($urandom_range(0, 1015));
        n  = int'($urandom_range(1, 8));
        if ($urandom_range(0, 1) == 1) begin
          d.delete(); be.delete();
          for (int k = 0; k < n; k++) begin
            d.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
            be.push_back(16'($urandom()));
          end
          wr_burst(u, 32'(wi*16) + 32'($urandom_range(0, 15)), n, d, be);
        end else begin
          rd_burst(u, 32'(wi*16), 8'(n), f);
        end
      end
      check1($sformatf("rand_err u%0d", u), err[u], merr[u]);
    end

    // Read running past the last word
    rd_burst(0, 32'((WORDS - 1) * 16), 8'd2, f);
    check("range_last_word", f, {16{8'hFF}});
    check1("range_err", err[0], 1'b1);

    // Reset during beat 2 of an 8-beat read
    @(negedge clk);
    read[0] = 1'b1; address[0] = 32'h200; burstcount[0] = 8'd8;
    wait_accept(0);
    @(negedge clk);
    read[0] = 1'b0;
    cnt = rdvalid[0] ? 1 : 0;
    t = 0;
    while (cnt < 2 && t < 50) begin
      @(negedge clk);
      if (rdvalid[0]) cnt++;
      t++;
    end
    check("rst_mid_beats_before", 128'(cnt), 128'(2));
    rst = 1'b1;
    #1;
    check1("rst_mid_valid_drop", rdvalid[0], 1'b0);
    check1("rst_mid_wait", waitreq[0], 1'b1);
    @(negedge clk);
    rst = 1'b0;
    merr[0] = 1'b0;
    merr[1] = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (rdvalid[0]) cnt++;
    end
    check("rst_mid_no_more_beats", 128'(cnt), 128'(0));
    rd_burst(0, 32'h200, 8'd8, f);
    check1("rst_mid_err", err[0], 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/avmm_burst_mem_slave.md
# avmm_burst_mem_slave

Synthesizable Avalon-MM burst memory responder: the slave end of the `mm_top` host port, answering its burst reads of A/B tiles and its byte-enabled writes of C. It sits between `mm_top` and on-chip RAM, so the full multiplier runs without external DDR. It also serves as the reusable memory model for system benches. Optional pseudo-random wait-state injection stresses the initiator's handshake logic.

## Interface
- DW, 128: data width in bits; equals HOST_DW (power of two, ≥32).
- MEM_WORDS, 1024: RAM depth in DW-bit words (power of two).
- BASE, 32'h0000_0000: byte address of word 0.
- STALL_EN, 0: 1 enables LFSR-driven wait-state/beat-gap injection.
- LFSR_SEED, 16'hACE1: non-zero LFSR reset value.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  **asynchronous, active-high reset.**
- avs_address  in  32  byte address; low log2(DW/8) bits ignored (word-aligned).
- avs_read  in  1  read command.
- avs_write  in  1  write command / write beat.
- avs_writedata  in  DW  write data.
- avs_byteenable  in  DW/8  per-byte write enable.
- avs_burstcount  in  8  beats in burst; 0 treated as 1.
- avs_readdata  out  DW  read data.
- avs_readdatavalid  out  1  one-cycle valid per read beat.
- avs_waitrequest  out  1  command/beat not accepted this cycle.
- err_sticky  out  1  sticky protocol/range error flag; cleared only by rst.

## Operation
- States: IDLE, RD_BURST, WR_BURST.
- stall = STALL_EN & (lfsr[1:0]==2'b00). The 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle.
- avs_waitrequest = rst | (state==RD_BURST) | stall. This is combinational from registers and rst only, with no path from the avs_* inputs.
- Acceptance: a command or beat is taken at an edge where (read|write) & !avs_waitrequest.
- IDLE, read accepted: latch word index = (address−BASE)>>log2(DW/8) and remaining = max(burstcount,1). Go to RD_BURST.
- RD_BURST:
  - On each non-stalled cycle, issue one beat from the current index: read RAM, increment the index, decrement remaining.
  - At the edge issuing the last beat, return to IDLE.
  - Read data is registered: beat data and avs_readdatavalid appear in the cycle after the issuing edge.
- IDLE, write accepted:
  - Write beat 0 with byteenable masking; only enabled bytes change.
  - If burstcount > 1, latch remaining−1 and index+1, and go to WR_BURST.
- WR_BURST:
  - Each accepted write beat writes the current index, increments it and decrements remaining; return to IDLE after the last beat.
  - avs_read asserted here is ignored and sets err_sticky.
- Read and write both high in IDLE: the write is serviced, the read is dropped, and err_sticky is set.
- Range check is per beat. A beat whose address < BASE or index ≥ MEM_WORDS returns 0 on reads and is discarded on writes; it sets err_sticky. Indices do not wrap.
- RAM contents are not affected by rst.

## Timing
- Reset values: avs_readdatavalid=0, avs_readdata=0, err_sticky=0, state=IDLE, lfsr=LFSR_SEED. avs_waitrequest=1 while rst is high.
- Read latency: with acceptance at edge E0 and STALL_EN=0, the edges that issue beats 0…n−1 are E1…En. avs_readdatavalid is high in the cycles after E1…En, so beats are back-to-back.
- The first read beat is valid 2 edges after acceptance. avs_waitrequest is high for the cycles following E0 through En.
- In the cycle after En, state=IDLE: a new command is acceptable while the final readdatavalid is high.
- Stall in RD_BURST: no beat is issued at that edge, which creates a one-cycle readdatavalid gap. Beat order and data are unchanged.
- Write: there is zero added latency. A RAM write takes effect at the acceptance edge, and a read issued at the next edge returns the new data.
- Reset asserted mid-burst: avs_readdatavalid drops immediately and the remaining beats are abandoned. After release, the block is in IDLE and accepts commands at the first edge.

## Test plan
- Preload word k = {16{k[7:0]}}. Read at address BASE+0x40, burstcount 4, STALL_EN=0 -> 4 consecutive valid beats with words 4,5,6,7. The first beat is valid 2 edges after acceptance, and waitrequest is high for exactly 4 cycles.
- Write word 0 all 0xFF, then write 0x0 with byteenable 16'h00F0 -> a read returns bytes 4-7 = 0x00 and all other bytes 0xFF.
- Write burst of 3 at BASE+0x100 with data 1,2,3 -> reads of words 16-18 return 1,2,3, and err_sticky stays 0.
- Read at BASE+(MEM_WORDS−1)*16, burstcount 2 -> beat 0 = last word, beat 1 = 0, and err_sticky=1.
- STALL_EN=1: run the 8×8 `mm_top` multiplication with A=I+1 and B[i][j]=j+1 -> C matches the golden model, and every burst delivers exactly burstcount beats.
- Assert rst for 1 cycle during beat 2 of an 8-beat read -> no further readdatavalid. A subsequent read of the same burst returns the full, correct 8 beats, and err_sticky=0.
